// File: rtl/seg7_pkg.sv
// Shared constants for the two-digit seven-segment to binary converter:
// active-low segment patterns (bit0=a .. bit6=g), sentinels and FSM encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] DIGIT_INVALID = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMBINE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // tens*10 + units via shift-add; the 8-bit sum is truncated to 7 bits.
    function automatic logic [6:0] tens_units_to_bin(input logic [3:0] tens,
                                                     input logic [3:0] units);
        return 7'({1'b0, tens, 3'b000} + {3'b000, tens, 1'b0} + {4'b0000, units});
    endfunction

endpackage

// File: rtl/seg7_digit_dec.sv
// Combinational lookup from one active-low segment pattern to a BCD digit.
// A blank pattern decodes as 0 only where leading-zero blanking is allowed.
module seg7_digit_dec
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    input  logic       blank_ok,
    output logic [3:0] digit,
    output logic       valid
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        digit = DIGIT_INVALID;
        valid = 1'b0;
        case (pattern)
            SEG_0: begin digit = 4'd0; valid = 1'b1; end
            SEG_1: begin digit = 4'd1; valid = 1'b1; end
            SEG_2: begin digit = 4'd2; valid = 1'b1; end
            SEG_3: begin digit = 4'd3; valid = 1'b1; end
            SEG_4: begin digit = 4'd4; valid = 1'b1; end
            SEG_5: begin digit = 4'd5; valid = 1'b1; end
            SEG_6: begin digit = 4'd6; valid = 1'b1; end
            SEG_7: begin digit = 4'd7; valid = 1'b1; end
            SEG_8: begin digit = 4'd8; valid = 1'b1; end
            SEG_9: begin digit = 4'd9; valid = 1'b1; end
            SEG_BLANK: begin
                if (blank_ok) begin
                    digit = 4'd0;
                    valid = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/seg7_decoder.sv
// Converts a two-digit seven-segment display reading into binary 0..99.
// Fixed four-state pipeline: latch, decode, combine, report with a done pulse.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic       clk,
    input  logic       clc,
    input  logic       start,
    input  logic [6:0] seg_unidades,
    input  logic [6:0] seg_decenas,
    output logic       busy,
    output logic       done,
    output logic [6:0] value,
    output logic [3:0] digit_unidades,
    output logic [3:0] digit_decenas,
    output logic       err
);

    state_e     state_q;
    logic [6:0] seg_u_q;
    logic [6:0] seg_d_q;
    logic [3:0] dig_u_q;
    logic [3:0] dig_d_q;
    logic       digits_ok_q;
    logic       busy_q;
    logic       done_q;
    logic [6:0] value_q;
    logic [3:0] out_u_q;
    logic [3:0] out_d_q;
    logic       err_q;

    logic [3:0] dec_u_digit;
    logic [3:0] dec_d_digit;
    logic       dec_u_valid;
    logic       dec_d_valid;

    seg7_digit_dec u_dec_unidades (
        .pattern  (seg_u_q),
        .blank_ok (1'b0),
        .digit    (dec_u_digit),
        .valid    (dec_u_valid)
    );

    // Leading-zero blanking applies to the tens digit only.
    seg7_digit_dec u_dec_decenas (
        .pattern  (seg_d_q),
        .blank_ok (1'b1),
        .digit    (dec_d_digit),
        .valid    (dec_d_valid)
    );

    // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
    always_ff @(posedge clk or negedge clc) begin
        if (!clc) begin
            state_q     <= ST_IDLE;
            seg_u_q     <= '0;
            seg_d_q     <= '0;
            dig_u_q     <= '0;
            dig_d_q     <= '0;
            digits_ok_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            value_q     <= '0;
            out_u_q     <= '0;
            out_d_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        seg_u_q <= seg_unidades;
                        seg_d_q <= seg_decenas;
                        busy_q  <= 1'b1;
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    dig_u_q     <= dec_u_digit;
                    dig_d_q     <= dec_d_digit;
                    digits_ok_q <= dec_u_valid & dec_d_valid;
                    state_q     <= ST_COMBINE;
                end
                ST_COMBINE: begin
                    out_u_q <= dig_u_q;
                    out_d_q <= dig_d_q;
                    value_q <= digits_ok_q ? tens_units_to_bin(dig_d_q, dig_u_q) : 7'd0;
                    err_q   <= ~digits_ok_q;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    // The report cycle may already accept the next request.
                    if (start) begin
                        seg_u_q <= seg_unidades;
                        seg_d_q <= seg_decenas;
                        state_q <= ST_CAPTURE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign value          = value_q;
    assign digit_unidades = out_u_q;
    assign digit_decenas  = out_d_q;
    assign err            = err_q;

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed bench for seg7_decoder: vector table for decode/combine results,
// plus hand-written sequences for back-to-back starts and mid-conversion reset.
module tb_seg7_decoder;

    logic       clk;
    logic       clc;
    logic       start;
    logic [6:0] seg_unidades;
    logic [6:0] seg_decenas;
    logic       busy;
    logic       done;
    logic [6:0] value;
    logic [3:0] digit_unidades;
    logic [3:0] digit_decenas;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_decoder dut (
        .clk            (clk),
        .clc            (clc),
        .start          (start),
        .seg_unidades   (seg_unidades),
        .seg_decenas    (seg_decenas),
        .busy           (busy),
        .done           (done),
        .value          (value),
        .digit_unidades (digit_unidades),
        .digit_decenas  (digit_decenas),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg_d;
        logic [6:0] seg_u;
        logic [6:0] value;
        logic [3:0] dig_d;
        logic [3:0] dig_u;
        logic       err;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_value"}, 32'(value), 32'd0);
        check({tag, "_dig_u"}, 32'(digit_unidades), 32'd0);
        check({tag, "_dig_d"}, 32'(digit_decenas), 32'd0);
        check({tag, "_err"},   32'(err), 32'd0);
    endtask

    // One isolated conversion; inputs are scrambled right after the accepting edge.
    task automatic convert(input vec_t v, input string tag);
        @(negedge clk);
        seg_decenas  = v.seg_d;
        seg_unidades = v.seg_u;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        seg_decenas  = 7'h55;
        seg_unidades = 7'h55;
        check({tag, "_busy_k"}, 32'(busy), 32'd1);
        check({tag, "_done_k"}, 32'(done), 32'd0);
        @(negedge clk);
        check({tag, "_done_k1"}, 32'(done), 32'd0);
        @(negedge clk);
        check({tag, "_done_k2"}, 32'(done), 32'd1);
        check({tag, "_busy_k2"}, 32'(busy), 32'd1);
        check({tag, "_value"},   32'(value), 32'(v.value));
        check({tag, "_dig_d"},   32'(digit_decenas), 32'(v.dig_d));
        check({tag, "_dig_u"},   32'(digit_unidades), 32'(v.dig_u));
        check({tag, "_err"},     32'(err), 32'(v.err));
        @(negedge clk);
        check({tag, "_done_k3"},  32'(done), 32'd0);
        check({tag, "_busy_k3"},  32'(busy), 32'd0);
        check({tag, "_value_hold"}, 32'(value), 32'(v.value));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [7:0] done_hist;

        vecs[0]  = '{7'h12, 7'h78, 7'd57, 4'd5, 4'd7, 1'b0};
        vecs[1]  = '{7'h7F, 7'h10, 7'd9,  4'd0, 4'd9, 1'b0};
        vecs[2]  = '{7'h10, 7'h10, 7'd99, 4'd9, 4'd9, 1'b0};
        vecs[3]  = '{7'h12, 7'h7F, 7'd0,  4'd5, 4'hF, 1'b1};
        vecs[4]  = '{7'h40, 7'h40, 7'd0,  4'd0, 4'd0, 1'b0};
        vecs[5]  = '{7'h40, 7'h55, 7'd0,  4'd0, 4'hF, 1'b1};
        vecs[6]  = '{7'h79, 7'h24, 7'd12, 4'd1, 4'd2, 1'b0};
        vecs[7]  = '{7'h30, 7'h19, 7'd34, 4'd3, 4'd4, 1'b0};
        vecs[8]  = '{7'h55, 7'h02, 7'd0,  4'hF, 4'd6, 1'b1};
        vecs[9]  = '{7'h02, 7'h00, 7'd68, 4'd6, 4'd8, 1'b0};
        vecs[10] = '{7'h7F, 7'h7F, 7'd0,  4'd0, 4'hF, 1'b1};

        clc          = 1'b0;
        start        = 1'b0;
        seg_unidades = 7'h7F;
        seg_decenas  = 7'h7F;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        clc = 1'b1;

        for (int i = 0; i < 11; i++) begin
            convert(vecs[i], $sformatf("vec%0d", i));
        end

        // Start held for six edges: accepts at k and k+3, busy cycles ignore it.
        @(negedge clk);
        seg_decenas  = 7'h12;
        seg_unidades = 7'h78;
        start        = 1'b1;
        done_hist    = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                seg_decenas  = 7'h79;
                seg_unidades = 7'h24;
            end
            if (i == 5) start = 1'b0;
            done_hist[i] = done;
            if (i == 2) check("b2b_first_value", 32'(value), 32'd57);
            if (i == 3) check("b2b_busy_reaccept", 32'(busy), 32'd1);
            if (i == 5) begin
                check("b2b_second_value", 32'(value), 32'd12);
                check("b2b_second_dig_d", 32'(digit_decenas), 32'd1);
                check("b2b_second_dig_u", 32'(digit_unidades), 32'd2);
            end
            if (i == 6) check("b2b_busy_idle", 32'(busy), 32'd0);
        end
        check("b2b_done_pattern", 32'(done_hist), 32'h24);

        // Reset pulse while in CAPTURE aborts the conversion.
        @(negedge clk);
        seg_decenas  = 7'h10;
        seg_unidades = 7'h10;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy_before", 32'(busy), 32'd1);
        clc = 1'b0;
        #1;
        check_all_zero("abort");
        #2;
        clc = 1'b1;
        done_hist = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            done_hist[i] = done;
        end
        check("abort_no_done", 32'(done_hist), 32'd0);
        check("abort_value_zero", 32'(value), 32'd0);

        v = '{7'h19, 7'h12, 7'd45, 4'd4, 4'd5, 1'b0};
        convert(v, "post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_decoder.md
SEG7_DECODER -- requirements
Module: seg7_decoder

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state on rising edge.
REQ-002 SHALL have port: clc  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  request to capture and decode the segment inputs.
REQ-004 SHALL have port: seg_unidades  input  7  units-digit segment pattern.
REQ-005 SHALL have port: seg_decenas  input  7  tens-digit segment pattern.
REQ-006 SHALL have port: busy  output  1  conversion in progress; start is ignored.
REQ-007 SHALL have port: done  output  1  one-cycle pulse; results are valid from this cycle on.
REQ-008 SHALL have port: value  output  7  binary result, 0..99.
REQ-009 SHALL have port: digit_unidades  output  4  decoded units digit, or 4'hF if invalid.
REQ-010 SHALL have port: digit_decenas  output  4  decoded tens digit, or 4'hF if invalid.
REQ-011 SHALL have port: err  output  1  last conversion contained an invalid pattern.

Function
REQ-012 SHALL use segment encoding bit0=a .. bit6=g, active-low (0 = lit).
REQ-013 SHALL treat only these patterns as valid, for digits 0..9: 0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78, 0x00, 0x10.
REQ-014 SHALL decode a blank pattern (0x7F) on seg_decenas as digit 0 (leading-zero blanking).
REQ-015 SHALL decode a blank on seg_unidades, and any other unlisted pattern on either input, as invalid (4'hF).
REQ-016 SHALL implement states IDLE, CAPTURE, COMBINE, DONE.
REQ-017 SHALL, in IDLE with start=1 at edge k, latch both segment inputs, set busy=1 and go to CAPTURE.
REQ-018 SHALL, in CAPTURE, register both decoded digits at edge k+1 and go to COMBINE.
REQ-019 SHALL, in COMBINE, register value = tens*10 + units at edge k+2, using shift-add (tens<<3)+(tens<<1)+units in an 8-bit intermediate truncated to 7 bits, then go to DONE.
REQ-020 SHALL drive done=1 and busy=1 only during the cycle between edges k+2 and k+3.
REQ-021 SHALL return to IDLE at edge k+3, with busy=0 from edge k+3 onwards.
REQ-022 SHALL accept a new start at edge k+3 at the earliest; done-to-done spacing is therefore at minimum 3 cycles.
REQ-023 SHALL ignore start whenever busy=1, with no queuing.
REQ-024 SHALL sample segment inputs only at the accepting edge; input changes afterwards do not affect the result.
REQ-025 SHALL, if either digit is invalid, set err=1 and value=0 at edge k+2, while still reporting both digit outputs (4'hF where invalid).
REQ-026 SHALL, on a valid conversion, clear err to 0 at edge k+2.
REQ-027 SHALL hold value, digit_*, and err stable from edge k+2 until the next conversion updates them at its own COMBINE edge.

Reset
REQ-028 SHALL, on clc=0, asynchronously force: state IDLE, busy=0, done=0, value=0, digit_unidades=0, digit_decenas=0, err=0, and clear the latched segment registers.
REQ-029 SHALL, if reset is asserted mid-conversion, abort the conversion with no done pulse; the first start is accepted on the first rising edge with clc=1.

Structure
REQ-030 SHALL place the 10 segment-pattern constants, the BLANK constant (0x7F), DIGIT_INVALID (4'hF) and the state encoding in shared package seg7_pkg.
REQ-031 SHALL implement pattern-to-digit lookup in combinational sub-module seg7_digit_dec (inputs: pattern, blank_ok; outputs: digit, valid), instantiated twice.

Verification
REQ-032 SHALL verify: start with seg_decenas=0x12, seg_unidades=0x78 -> done 3 cycles later, value=57, digits 5/7, err=0.
REQ-033 SHALL verify: seg_decenas=0x7F, seg_unidades=0x10 -> value=9, digit_decenas=0, err=0; seg_decenas=0x10, seg_unidades=0x10 -> value=99.
REQ-034 SHALL verify: seg_unidades=0x7F or 0x55 -> err=1, value=0, digit_unidades=4'hF.
REQ-035 SHALL verify: start held high for 6 cycles -> exactly two done pulses, 3 cycles apart; segment changes after the accepting edge do not alter the result.
REQ-036 SHALL verify: clc pulsed low during CAPTURE -> all outputs 0 immediately, no done pulse; next start converts normally.
